output_display: RTL and testbench
=================================

// Module: output_display
// PURPOSE
//  - Output register and 4-digit seven-segment driver for the 8-bit CPU; consumer of the shared dataBus when OI is asserted.
//  - Captures the bus byte, converts it to BCD with an iterative double-dabble engine, and time-multiplexes the digits.
//  - Sits beside the A/B/IR registers on dataBus; drives board segment/anode pins.
// PARAMETERS
//  - SCAN_DIV   1000  clk cycles each digit stays enabled (>=2)
//  - SEG_ACT_LO 1     1: seg/dig_en active-low pins; 0: active-high
// PORTS
//  - clk      in   1  system clock (CPU clk domain)
//  - rst      in   1  reset, asynchronous, active-low
//  - data_in  in   8  dataBus value
//  - load     in   1  OI control; capture data_in on rising clk edge
//  - seg      out  7  segments {g,f,e,d,c,b,a}
//  - dig_en   out  4  one-hot digit enable, bit0 = rightmost digit
//  - busy     out  1  conversion in progress
// BEHAVIOUR
//  - One clock; every flop async-cleared while rst low. No other reset.
//  - Reset values:
//    - out_reg = 0; displayed BCD = 000; busy = 0; FSM = IDLE; scan counter = 0; digit index = 0.
//    - seg and dig_en = all-off pattern (polarity per SEG_ACT_LO).
//  - FSM IDLE -> CONV -> LATCH -> IDLE.
//    - IDLE: load=1 at edge -> out_reg<=data_in, shift reg<=data_in, BCD<=0, iter<=0, go to CONV; busy=1 from next cycle.
//    - CONV: 8 cycles. Each cycle adds 3 to any BCD nibble >=5, then shifts {bcd,bin} left by 1. iter 0..7; iter==7 -> LATCH.
//    - LATCH: 1 cycle; copy BCD to display regs; busy=0 next cycle; go to IDLE.
//    - Load edge to new digits visible = 10 cycles; display keeps old value until LATCH.
//  - load while busy (CONV/LATCH): restart with new data_in (last write wins); aborted result never displayed.
//  - load held high: recaptures every cycle; converts the value present on the last asserted cycle.
//  - Widths: BCD 12 bits (hundreds<=2), shift register 20 bits; max 255 -> 2,5,5.
//  - Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens both 0; ones always shown. Digit3 blank (unsigned).
//  - Scan: counter 0..SCAN_DIV-1 free-running; at SCAN_DIV-1 wraps to 0 and digit index increments mod 4 (3->0).
//  - seg/dig_en registered: one cycle after index change.
//  - Exactly one dig_en bit active at any time after the first post-reset cycle.
//  - Decoder: 0-9 standard patterns; blank = all off.
//  - Scanning is independent of FSM; reset mid-conversion returns to IDLE and display 0.
// CONFIGURATION
//  - `SIGNED_DISPLAY_EN defined:
//    - Extra input signed_mode (1 bit, after load).
//    - signed_mode=1 and data_in[7]=1 -> convert magnitude (-data_in, 8-bit; -128 -> 128); digit3 shows minus (seg g only).
//    - Otherwise unsigned.
//    - signed_mode sampled with data_in on load.
//  - Not defined: port absent, always unsigned, digit3 always blank.
// STRUCTURE
//  - Package display_pkg: FSM state enum (IDLE/CONV/LATCH), SEG_BLANK, SEG_MINUS, 10-entry digit-to-segment constant table, NUM_DIGITS=4.
//  - Sub-module bin2bcd: double-dabble FSM.
//    - Ports clk, rst, start, bin[7:0], bcd[11:0], busy, done.
//    - Top holds out_reg, display regs, scan counter, decoder.
// TESTING
//  - Reset: rst low mid-scan -> seg/dig_en all-off immediately, busy=0; release -> ones digit shows "0", others blank.
//  - load=1 with data_in=8'd255 -> busy high 9 cycles; digits 2,5,5 after 10 cycles; digit3 blank.
//  - data_in=8'd7 -> hundreds/tens blank, ones "7"; data_in=8'd100 -> "100" (no tens blanking).
//  - Load 8'd42, then load 8'd199 at CONV iter 4 -> display never shows 42, shows 199 ten cycles after 2nd load.
//  - SCAN_DIV=4: dig_en cycles 0001,0010,0100,1000 (active-high view), 4 cycles each, wraps to 0001.
//  - SIGNED_DISPLAY_EN: signed_mode=1, data_in=8'hFF -> "-  1"; data_in=8'h80 -> "-128"; signed_mode=0, data_in=8'h80 -> "128".

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the output display: conversion FSM states,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and the
// double-dabble step used by the BCD converter.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Non-decimal nibbles map to blank so a corrupted digit never lights garbage.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    if (d < 4'd10) return SEG_DIGITS[d];
    return SEG_BLANK;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: correct every
  // BCD nibble that would overflow on doubling, then shift left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int n = 0; n < 3; n++) begin
      if (a[8+4*n +: 4] >= 4'd5) a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// IDLE -> CONV (8 cycles) -> LATCH (1 cycle) -> IDLE. A start pulse in any
// state restarts from the new operand, so an interrupted conversion never
// raises done. Handshake: start is a single-cycle request sampled on the
// clock edge; done is high for exactly the LATCH cycle of an uninterrupted
// conversion and bcd is valid whenever done is high.
module bin2bcd
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_e state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start always wins so the last write is converted
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CONV;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CONV:    if (iter_q == 3'd7) state_d = LATCH;
        LATCH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      iter_q  <= '0;
    end else begin
      shift_q <= shift_d;
      iter_q  <= iter_d;
    end
  end

  // Datapath next values: load operand on start, one dabble step per CONV cycle
  always_comb begin
    shift_d = shift_q;
    iter_d  = iter_q;
    if (start) begin
      shift_d = {12'd0, bin};
      iter_d  = 3'd0;
    end else if (state_q == CONV) begin
      shift_d = dabble_step(shift_q);
      iter_d  = iter_q + 3'd1;
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == LATCH) && !start;
    bcd  = shift_q[19:8];
  end

endmodule

// File: rtl/output_display.sv
// CPU output register with 4-digit multiplexed seven-segment driver.
// A load captures the bus byte, bin2bcd converts it, and the result is
// copied into the display registers when conversion completes. Digits are
// scanned round-robin, SCAN_DIV clocks each, with leading-zero blanking.
// Optional build macro SIGNED_DISPLAY_EN adds a signed_mode input: negative
// bytes are shown as magnitude with a minus sign on the leftmost digit.
module output_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
`ifdef SIGNED_DISPLAY_EN
  input  logic       signed_mode,
`endif
  output logic [6:0] seg,
  output logic [3:0] dig_en,
  output logic       busy
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [6:0]            SEG_OFF = SEG_ACT_LO ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = SEG_ACT_LO ? '1 : '0;

  logic [7:0]       out_reg_q, out_reg_d;
  logic             neg_d, neg_cur;
  logic [7:0]       conv_bin;
  logic [11:0]      conv_bcd;
  logic             conv_done;
  logic [11:0]      disp_bcd_q;
  logic             disp_neg_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [IDX_W-1:0] dig_idx_q;
  logic [6:0]       seg_q, seg_d, pat;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d, onehot;

  // Output register follows the bus only while OI is asserted
  always_comb out_reg_d = load ? data_in : out_reg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_reg_q <= '0;
    else      out_reg_q <= out_reg_d;
  end

`ifdef SIGNED_DISPLAY_EN
  logic mode_q, mode_d;

  // Signed mode is sampled together with the data byte
  always_comb mode_d = load ? signed_mode : mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= 1'b0;
    else      mode_q <= mode_d;
  end

  // neg_d describes the byte entering conversion, neg_cur the one held
  always_comb begin
    neg_d   = mode_d & out_reg_d[7];
    neg_cur = mode_q & out_reg_q[7];
  end
`else
  // Unsigned build: never negative
  always_comb begin
    neg_d   = 1'b0;
    neg_cur = 1'b0;
  end
`endif

  // Magnitude fed to the converter; -128 wraps to 8'h80, which is 128
  always_comb conv_bin = neg_d ? (8'd0 - out_reg_d) : out_reg_d;

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .busy  (busy),
    .done  (conv_done)
  );

  // Display registers change only on a completed, uninterrupted conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd;
      disp_neg_q <= neg_cur;
    end
  end

  // Free-running scan counter; digit index advances on counter wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
    end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= dig_idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + CNT_W'(1);
    end
  end

  // Segment pattern for the selected digit with leading-zero blanking
  always_comb begin
    pat = SEG_BLANK;
    case (dig_idx_q)
      2'd0: pat = digit_to_seg(disp_bcd_q[3:0]);
      2'd1: if (disp_bcd_q[11:4] != 8'd0) pat = digit_to_seg(disp_bcd_q[7:4]);
      2'd2: if (disp_bcd_q[11:8] != 4'd0) pat = digit_to_seg(disp_bcd_q[11:8]);
      2'd3: if (disp_neg_q) pat = SEG_MINUS;
      default: pat = SEG_BLANK;
    endcase
    onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx_q;
    seg_d    = SEG_ACT_LO ? ~pat : pat;
    dig_en_d = SEG_ACT_LO ? ~onehot : onehot;
  end

  // Registered pin drivers; all-off while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q    <= SEG_OFF;
      dig_en_q <= DIG_OFF;
    end else begin
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  always_comb begin
    seg    = seg_q;
    dig_en = dig_en_q;
  end

endmodule

// File: tb/tb_output_display.sv
`timescale 1ns/1ps
module tb_output_display;

  localparam int SD = 4;
`ifdef SIGNED_DISPLAY_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       load = 1'b0;
`ifdef SIGNED_DISPLAY_EN
  logic       signed_mode = 1'b0;
`endif
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       busy;

  always #5 clk = ~clk;

  output_display #(.SCAN_DIV(SD), .SEG_ACT_LO(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .load        (load),
`ifdef SIGNED_DISPLAY_EN
    .signed_mode (signed_mode),
`endif
    .seg         (seg),
    .dig_en      (dig_en),
    .busy        (busy)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: edge count since reset, last load edge, values
  int cyc = 0;
  int last_load = -100;
  int pend_val = 0;
  bit pend_neg = 1'b0;
  int disp_val = 0;
  bit disp_neg = 1'b0;
  int prev_val = 0;
  bit prev_neg = 1'b0;
  bit chk_en = 1'b0;

  function automatic logic [6:0] digit_pat(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  // Active-high pattern that digit idx must show for value v
  function automatic logic [6:0] exp_pat(input int idx, input int v, input bit neg);
    case (idx)
      0: return digit_pat(v % 10);
      1: return (v >= 10) ? digit_pat((v / 10) % 10) : 7'h00;
      2: return (v >= 100) ? digit_pat(v / 100) : 7'h00;
      default: return neg ? 7'h40 : 7'h00;
    endcase
  endfunction

  task automatic model_edge(input bit ld, input logic [7:0] d, input bit sm);
    bit neg;
    prev_val = disp_val;
    prev_neg = disp_neg;
    cyc++;
    if (ld) begin
      neg       = SIGNED_EN && sm && d[7];
      last_load = cyc;
      pend_neg  = neg;
      pend_val  = neg ? 256 - int'(d) : int'(d);
    end else if (cyc - last_load == 9) begin
      disp_val = pend_val;
      disp_neg = pend_neg;
    end
  endtask

  // Compare process: every cycle outputs are checked against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [6:0] e_seg;
      logic [3:0] e_dig;
      int idx;
      if (cyc == 0) begin
        e_seg = 7'h7F;
        e_dig = 4'hF;
      end else begin
        idx   = ((cyc - 1) / SD) % 4;
        e_dig = ~(4'b0001 << idx);
        e_seg = ~exp_pat(idx, prev_val, prev_neg);
      end
      check("cyc_seg", seg, e_seg);
      check("cyc_dig_en", dig_en, e_dig);
      check("cyc_busy", busy, (cyc - last_load) <= 8);
    end
  end

  // Driver tasks
  task automatic drive(input bit ld, input logic [7:0] d, input bit sm);
    load    = ld;
    data_in = d;
`ifdef SIGNED_DISPLAY_EN
    signed_mode = sm;
`endif
    @(posedge clk);
    model_edge(ld, d, sm);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst    = 1'b0;
    load   = 1'b0;
    #2;
    check("rst_seg", seg, 7'h7F);
    check("rst_dig_en", dig_en, 4'hF);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    cyc = 0; last_load = -100; pend_val = 0; pend_neg = 1'b0;
    disp_val = 0; disp_neg = 1'b0; prev_val = 0; prev_neg = 1'b0;
    rst    = 1'b1;
    chk_en = 1'b1;
  endtask

  // Wait (bounded) until digit idx is enabled, then check its literal pattern
  task automatic expect_digit(input int idx, input logic [6:0] lit, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 4 * SD + 2 && !found; k++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      if (dig_en == ~(4'b0001 << idx)) begin
        found = 1'b1;
        check(name, seg, lit);
      end
    end
    if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int bcnt;
    #12;
    do_reset();

    // Scan order literals with SCAN_DIV=4
    drive(1'b0, 8'd0, 1'b0);
    check("scan_first", dig_en, 4'hE);
    idle(4);
    check("scan_second", dig_en, 4'hD);
    expect_digit(0, 7'h40, "reset_ones_0");
    expect_digit(1, 7'h7F, "reset_tens_blank");

    // 255: busy nine cycles, then 2,5,5
    drive(1'b1, 8'd255, 1'b0);
    bcnt = busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 8'd0, 1'b0);
      if (busy) bcnt++;
    end
    check("busy_len_255", bcnt, 9);
    expect_digit(0, 7'h12, "d255_ones");
    expect_digit(1, 7'h12, "d255_tens");
    expect_digit(2, 7'h24, "d255_hund");
    expect_digit(3, 7'h7F, "d255_d3_blank");

    // 7: leading zeros blanked
    drive(1'b1, 8'd7, 1'b0);
    idle(12);
    expect_digit(0, 7'h78, "d7_ones");
    expect_digit(1, 7'h7F, "d7_tens_blank");
    expect_digit(2, 7'h7F, "d7_hund_blank");

    // 100: embedded zeros shown
    drive(1'b1, 8'd100, 1'b0);
    idle(12);
    expect_digit(0, 7'h40, "d100_ones");
    expect_digit(1, 7'h40, "d100_tens");
    expect_digit(2, 7'h79, "d100_hund");

    // 42 aborted mid-conversion by 199
    drive(1'b1, 8'd42, 1'b0);
    idle(4);
    drive(1'b1, 8'd199, 1'b0);
    idle(12);
    expect_digit(0, 7'h10, "d199_ones");
    expect_digit(1, 7'h10, "d199_tens");
    expect_digit(2, 7'h79, "d199_hund");

    // Load landing on the LATCH cycle
    drive(1'b1, 8'd50, 1'b0);
    idle(8);
    drive(1'b1, 8'd60, 1'b0);
    idle(12);
    expect_digit(1, 7'h02, "d60_tens");

    // Load held high with changing data
    for (int k = 0; k < 6; k++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    idle(12);

`ifdef SIGNED_DISPLAY_EN
    drive(1'b1, 8'hFF, 1'b1);
    idle(12);
    expect_digit(0, 7'h79, "sFF_ones");
    expect_digit(1, 7'h7F, "sFF_tens_blank");
    expect_digit(3, 7'h3F, "sFF_minus");
    drive(1'b1, 8'h80, 1'b1);
    idle(12);
    expect_digit(0, 7'h00, "s80_ones");
    expect_digit(2, 7'h79, "s80_hund");
    expect_digit(3, 7'h3F, "s80_minus");
    drive(1'b1, 8'h80, 1'b0);
    idle(12);
    expect_digit(1, 7'h24, "u80_tens");
    expect_digit(3, 7'h7F, "u80_no_minus");
`endif

    // Random traffic
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    idle(12);

    // Reset mid-conversion, then display returns to 0
    drive(1'b1, 8'd213, 1'b0);
    idle(3);
    do_reset();
    idle(2);
    expect_digit(0, 7'h40, "postrst_ones_0");
    expect_digit(2, 7'h7F, "postrst_hund_blank");
    idle(2 * SD);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
